// File: rtl/kreg_pkg.sv
// Shared definitions for the K-bit shift register command sequencer:
// operation encodings, controller state type and default register width.
package kreg_pkg;

    localparam int K_DEF = 5;

    // Mode-select encodings understood by the K-bit register.
    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b011;
    localparam logic [2:0] OP_LFSR = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CAP  = 2'd2,
        DONE = 2'd3
    } kreg_state_e;

    // Encodings 101..111 have no meaning to the register.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_LFSR);
    endfunction

    // Operations whose step count comes from the command length field.
    function automatic logic op_is_stepped(input logic [2:0] op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_LFSR);
    endfunction

endpackage

// File: rtl/kreg_step_timer.sv
// Step timer: counts clk cycles 0..STEP_CYC-1 while enabled and strobes
// wrap on the last cycle of each register operation step (one full pulse
// chain). Cleared whenever disabled so every enable starts a fresh step.
module kreg_step_timer #(
    parameter int STEP_CYC = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic wrap
);

    localparam logic [3:0] LAST = 4'(STEP_CYC - 1);

    generate
        if (STEP_CYC < 1 || STEP_CYC > 15) begin : g_bad_step_cyc
            $error("kreg_step_timer: STEP_CYC must be 1..15");
        end
    endgenerate

    logic [3:0] cnt_d;
    logic [3:0] cnt_q;

    // Next cycle count: hold at zero when idle, wrap at the end of a step.
    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    assign wrap = en && (cnt_q == LAST);

    // Cycle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/k_bit_reg_ctrl.sv
// Command sequencer for the multi-operational K-bit shift register.
// Accepts one command over valid/ready, drives the register's mode select
// and parallel inputs for the requested number of steps, then captures
// the register outputs into result and pulses done.
//
// Optional build macro: KREG_ZERO_SEED_GUARD_EN
//   When defined, an LFSR command that starts with an all-zero register
//   first performs one parallel-load step of {0..0,1} so the LFSR can run.
//
// state | meaning
// IDLE  | sel=hold, cmd_ready=1, waiting for a command
// RUN   | sel/ip driven, stepping until the step count reaches zero
// CAP   | sel=hold for one cycle so the last latch phase settles
// DONE  | capture taken; done (and err for an illegal op) issued next
module k_bit_reg_ctrl
    import kreg_pkg::*;
#(
    parameter int K        = K_DEF,
    parameter int CNT_W    = 8,
    parameter int STEP_CYC = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic [K-1:0]     cmd_data,
    input  logic [K-1:0]     reg_q,
    output logic [2:0]       sel,
    output logic [K-1:0]     ip,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [K-1:0]     result
);

    kreg_state_e      state_d, state_q;
    logic [CNT_W-1:0] step_d, step_q;
    logic [CNT_W-1:0] step_dec;
    logic             seed_d, seed_q;
    logic             illegal_d, illegal_q;
    logic [2:0]       sel_d, sel_q;
    logic [K-1:0]     ip_d, ip_q;
    logic [K-1:0]     result_d, result_q;
    logic             done_d, done_q;
    logic             err_d, err_q;
    logic             step_wrap;
    logic             xfer;

    kreg_step_timer #(
        .STEP_CYC (STEP_CYC)
    ) u_step_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == RUN),
        .wrap  (step_wrap)
    );

    assign xfer     = cmd_valid && (state_q == IDLE);
    assign step_dec = step_q - CNT_W'(1);

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        seed_d    = seed_q;
        illegal_d = illegal_q;
        sel_d     = sel_q;
        ip_d      = ip_q;
        result_d  = result_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                sel_d = OP_HOLD;
                ip_d  = '0;
                if (xfer) begin
                    illegal_d = !op_is_legal(cmd_op);
                    seed_d    = 1'b0;
                    if (cmd_op == OP_LOAD) begin
                        // A load is always exactly one step, whatever cmd_len says.
                        state_d = RUN;
                        step_d  = CNT_W'(1);
                        sel_d   = OP_LOAD;
                        ip_d    = cmd_data;
                    end else if (op_is_stepped(cmd_op) && (cmd_len != '0)) begin
                        state_d = RUN;
                        step_d  = cmd_len;
                        sel_d   = cmd_op;
`ifdef KREG_ZERO_SEED_GUARD_EN
                        // An all-zero LFSR never leaves zero; seed it with one
                        // extra load step that does not consume the step count.
                        if ((cmd_op == OP_LFSR) && (reg_q == '0)) begin
                            seed_d = 1'b1;
                            sel_d  = OP_LOAD;
                            ip_d   = K'(1);
                        end
`endif
                    end else begin
                        // Hold, zero-length or illegal: no register activity.
                        state_d = DONE;
                    end
                end
            end

            RUN: begin
                if (step_wrap) begin
                    if (seed_q) begin
                        seed_d = 1'b0;
                        sel_d  = OP_LFSR;
                        ip_d   = '0;
                    end else begin
                        step_d = step_dec;
                        if (step_dec == '0) begin
                            state_d = CAP;
                            sel_d   = OP_HOLD;
                            ip_d    = '0;
                        end
                    end
                end
            end

            CAP: begin
                result_d = reg_q;
                state_d  = DONE;
            end

            DONE: begin
                done_d    = 1'b1;
                err_d     = illegal_q;
                illegal_d = 1'b0;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
                sel_d   = OP_HOLD;
                ip_d    = '0;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            step_q    <= '0;
            seed_q    <= 1'b0;
            illegal_q <= 1'b0;
            sel_q     <= OP_HOLD;
            ip_q      <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            seed_q    <= seed_d;
            illegal_q <= illegal_d;
            sel_q     <= sel_d;
            ip_q      <= ip_d;
            result_q  <= result_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign sel       = sel_q;
    assign ip        = ip_q;
    assign done      = done_q;
    assign err       = err_q;
    assign result    = result_q;

endmodule

// File: tb/tb_k_bit_reg_ctrl.sv
// Testbench for k_bit_reg_ctrl: a behavioural K-bit register plant closes
// the loop; issued commands push their hand-computed response onto a
// scoreboard which a done-triggered monitor pops and compares.
module tb_k_bit_reg_ctrl;

    localparam int K        = 5;
    localparam int CNT_W    = 8;
    localparam int STEP_CYC = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = 3'b000;
    logic [CNT_W-1:0] cmd_len = '0;
    logic [K-1:0]     cmd_data = '0;
    logic [K-1:0]     reg_q;
    logic [2:0]       sel;
    logic [K-1:0]     ip;
    logic             busy;
    logic             done;
    logic             err;
    logic [K-1:0]     result;

    k_bit_reg_ctrl #(
        .K        (K),
        .CNT_W    (CNT_W),
        .STEP_CYC (STEP_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .reg_q     (reg_q),
        .sel       (sel),
        .ip        (ip),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .result    (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register plant: one operation per STEP_CYC cycles of non-hold select.
    logic [K-1:0] plant_q = '0;
    int           pcnt = 0;
    always @(posedge clk) begin
        if (sel == 3'b000) begin
            pcnt <= 0;
        end else if (pcnt == STEP_CYC - 1) begin
            pcnt <= 0;
            case (sel)
                3'b001:  plant_q <= plant_q >> 1;
                3'b010:  plant_q <= plant_q << 1;
                3'b011:  plant_q <= ip;
                3'b100:  plant_q <= {plant_q[3:0], plant_q[4] ^ plant_q[2]};
                default: ;
            endcase
        end else begin
            pcnt <= pcnt + 1;
        end
    end
    assign reg_q = plant_q;

    typedef struct {
        string        name;
        logic         err;
        logic [K-1:0] result;
        int           lat;
        int           start;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   passed = 0;
    int   last_start = 0;
    int   act_cnt = 0;
    int   match_cnt = 0;
    logic [2:0]   watch_sel = 3'b000;
    logic [K-1:0] watch_ip = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: select activity accounting plus scoreboard compare on done.
    always @(negedge clk) begin
        exp_t e;
        if (sel != 3'b000) begin
            act_cnt++;
            if (sel == watch_sel && ip == watch_ip) match_cnt++;
        end
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, "_err"}, 32'(err), 32'(e.err));
                check({e.name, "_result"}, 32'(result), 32'(e.result));
                check({e.name, "_latency"}, 32'(cyc - e.start), 32'(e.lat));
            end
        end
    end

    task automatic issue(input string name, input logic [2:0] op, input logic [CNT_W-1:0] len,
                         input logic [K-1:0] data, input bit push, input logic e_err,
                         input logic [K-1:0] e_res, input int e_lat);
        int   n = 0;
        exp_t e;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 3000);
        if (!cmd_ready) begin
            total++;
            $display("FAIL %s_accept: got cmd_ready=0 after %0d cycles, expected 1", name, n);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        last_start = cyc;
        if (push) begin
            e.name   = name;
            e.err    = e_err;
            e.result = e_res;
            e.lat    = e_lat;
            e.start  = cyc;
            sb.push_back(e);
        end
    endtask

    // Drop valid and scramble the command fields; the DUT must ignore them.
    task automatic drop();
        cmd_valid = 1'b0;
        cmd_op    = 3'b101;
        cmd_len   = 8'hAA;
        cmd_data  = ~cmd_data;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while ((sb.size() != 0 || !cmd_ready) && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0 || !cmd_ready) begin
            total++;
            $display("FAIL drain_timeout: got %0d pending after %0d cycles, expected 0", sb.size(), n);
            sb.delete();
        end
    endtask

    task automatic watch(input logic [2:0] s, input logic [K-1:0] d);
        watch_sel = s;
        watch_ip  = d;
        act_cnt   = 0;
        match_cnt = 0;
    endtask

    int s1;

    initial begin
        #12;
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_ip", 32'(ip), 32'h0);
        check("rst_result", 32'(result), 32'h0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;

        watch(3'b011, 5'b10110);
        issue("load", 3'b011, 8'd0, 5'b10110, 1, 1'b0, 5'b10110, 7);
        drop();
        drain(100);
        check("load_sel_cycles", 32'(act_cnt), 32'd5);
        check("load_ip_cycles", 32'(match_cnt), 32'd5);

        watch(3'b001, 5'b00000);
        issue("shr2", 3'b001, 8'd2, 5'b11111, 1, 1'b0, 5'b00101, 12);
        drop();
        drain(100);
        check("shr2_sel_cycles", 32'(act_cnt), 32'd10);
        check("shr2_ip_cycles", 32'(match_cnt), 32'd10);

        issue("hold", 3'b000, 8'd3, 5'b11111, 1, 1'b0, 5'b00101, 1);
        drop();
        drain(100);

        watch(3'b000, 5'b00000);
        issue("illegal", 3'b110, 8'd3, 5'b11111, 1, 1'b1, 5'b00101, 1);
        drop();
        drain(100);
        check("illegal_sel_quiet", 32'(act_cnt), 32'd0);

        issue("shl_len0", 3'b010, 8'd0, 5'b11111, 1, 1'b0, 5'b00101, 1);
        drop();
        drain(100);

        issue("shl1", 3'b010, 8'd1, 5'b00000, 1, 1'b0, 5'b01010, 7);
        drop();
        drain(100);

        issue("b2b_load", 3'b011, 8'd0, 5'b11001, 1, 1'b0, 5'b11001, 7);
        s1 = last_start;
        issue("b2b_shr", 3'b001, 8'd1, 5'b00000, 1, 1'b0, 5'b01100, 7);
        check("b2b_gap", 32'(last_start - s1), 32'd8);
        drop();
        drain(100);

        issue("load_zero", 3'b011, 8'd0, 5'b00000, 1, 1'b0, 5'b00000, 7);
        drop();
        drain(100);
`ifdef KREG_ZERO_SEED_GUARD_EN
        issue("lfsr_zero", 3'b100, 8'd3, 5'b00000, 1, 1'b0, 5'b01001, 22);
`else
        issue("lfsr_zero", 3'b100, 8'd3, 5'b00000, 1, 1'b0, 5'b00000, 17);
`endif
        drop();
        drain(100);

        issue("load_one", 3'b011, 8'd0, 5'b00001, 1, 1'b0, 5'b00001, 7);
        drop();
        drain(100);
        issue("lfsr3", 3'b100, 8'd3, 5'b00000, 1, 1'b0, 5'b01001, 17);
        drop();
        drain(100);

        issue("load_ones", 3'b011, 8'd0, 5'b11111, 1, 1'b0, 5'b11111, 7);
        drop();
        drain(100);
        issue("shr_max", 3'b001, 8'd255, 5'b00000, 1, 1'b0, 5'b00000, 1277);
        drop();
        drain(2000);

        issue("rst_run", 3'b001, 8'd4, 5'b00000, 0, 1'b0, 5'b00000, 0);
        drop();
        repeat (7) @(posedge clk);
        #2;
        check("mid_busy", 32'(busy), 32'h1);
        check("mid_cmd_ready", 32'(cmd_ready), 32'h0);
        check("mid_sel", 32'(sel), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_run_sel", 32'(sel), 32'h0);
        check("rst_run_busy", 32'(busy), 32'h0);
        check("rst_run_cmd_ready", 32'(cmd_ready), 32'h1);
        check("rst_run_done", 32'(done), 32'h0);
        check("rst_run_result", 32'(result), 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        issue("post_rst_hold", 3'b000, 8'd0, 5'b00000, 1, 1'b0, 5'b00000, 1);
        drop();
        drain(100);
        repeat (10) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation time %0t, expected completion earlier", $time);
        $fatal(1);
    end

endmodule
